// File: rtl/data_sram_slave_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_sram_slave_pkg : shared constants and FSM encoding for the data SRAM slave
// Revision 1.0
// ---------------------------------------------------------------------------
package data_sram_slave_pkg;

    localparam int DATA_SRAM_AW = 32;

    typedef enum logic [0:0] {
        DSRAM_IDLE = 1'b0,
        DSRAM_BUSY = 1'b1
    } dsram_state_t;

    // Wait counter width, never narrower than one bit.
    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_sram_slave_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_sram_slave_if : execute/memory-stage data SRAM request and response bus
// Revision 1.0
// ---------------------------------------------------------------------------
interface data_sram_slave_if;
    import data_sram_slave_pkg::*;

    logic                    data_sram_en;
    logic [3:0]              data_sram_we;
    logic [DATA_SRAM_AW-1:0] data_sram_addr;
    logic [DATA_SRAM_AW-1:0] data_sram_wdata;
    logic [DATA_SRAM_AW-1:0] data_sram_rdata;
    logic                    stallreq_mem;
    logic                    bus_err;

    modport master (
        output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, stallreq_mem, bus_err
    );

    modport slave (
        input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, stallreq_mem, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/data_sram_slave_dsram_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsram_array : single-port word array, byte-lane writes, registered read port
// Revision 1.0
// ---------------------------------------------------------------------------
module dsram_array
    import data_sram_slave_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic [ADDR_W-1:0]       idx,
    input  wire logic [3:0]              we,
    input  wire logic [DATA_SRAM_AW-1:0] wdata,
    input  wire logic                    rd_ld,
    input  wire logic                    rd_zero,
    output logic      [DATA_SRAM_AW-1:0] rdata
);

    logic [DATA_SRAM_AW-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                r_mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Out-of-range reads return zero instead of the aliased word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rd_ld) begin
            rdata <= rd_zero ? '0 : r_mem[idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_sram_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_sram_slave : data SRAM responder with optional read wait states
// Revision 1.0
// ---------------------------------------------------------------------------
module data_sram_slave
    import data_sram_slave_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    data_sram_slave_if.slave  bus
);

    localparam int               c_cnt_w    = cnt_width(WAIT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_load =
        c_cnt_w'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    dsram_state_t          r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [ADDR_W-1:0]     r_idx;
    logic                  r_oor;
    logic                  r_bus_err;

    logic                    w_oor;
    logic [ADDR_W-1:0]       w_idx;
    logic                    w_read;
    logic                    w_accept_wait;
    logic                    w_idle_done;
    logic                    w_busy_done;
    logic [ADDR_W-1:0]       w_arr_idx;
    logic [3:0]              w_arr_we;
    logic                    w_rd_ld;
    logic                    w_rd_zero;
    logic                    w_stall;
    logic [DATA_SRAM_AW-1:0] w_rdata;

    always_comb begin
        w_oor         = (bus.data_sram_addr >> (ADDR_W + 2)) != '0;
        w_idx         = bus.data_sram_addr[ADDR_W+1:2];
        w_read        = bus.data_sram_en && (bus.data_sram_we == 4'h0);
        w_accept_wait = (r_state == DSRAM_IDLE) && w_read && (WAIT_CYCLES > 0);
        w_idle_done   = (r_state == DSRAM_IDLE) && bus.data_sram_en && !w_accept_wait;
        w_busy_done   = (r_state == DSRAM_BUSY) && (r_cnt == '0);
        // While BUSY the array serves the request captured at accept time.
        w_arr_idx     = (r_state == DSRAM_BUSY) ? r_idx : w_idx;
        w_arr_we      = (w_idle_done && !w_oor) ? bus.data_sram_we : 4'h0;
        w_rd_ld       = (w_idle_done && w_read) || w_busy_done;
        w_rd_zero     = (r_state == DSRAM_BUSY) ? r_oor : w_oor;
        w_stall       = rst_n && (w_accept_wait || ((r_state == DSRAM_BUSY) && (r_cnt != '0)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= DSRAM_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_oor     <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= (w_idle_done && w_oor) || (w_busy_done && r_oor);
            case (r_state)
                DSRAM_IDLE: begin
                    if (w_accept_wait) begin
                        r_state <= DSRAM_BUSY;
                        r_cnt   <= c_cnt_load;
                        r_idx   <= w_idx;
                        r_oor   <= w_oor;
                    end
                end
                DSRAM_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= DSRAM_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= DSRAM_IDLE;
            endcase
        end
    end

    dsram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .idx     (w_arr_idx),
        .we      (w_arr_we),
        .wdata   (bus.data_sram_wdata),
        .rd_ld   (w_rd_ld),
        .rd_zero (w_rd_zero),
        .rdata   (w_rdata)
    );

    assign bus.data_sram_rdata = w_rdata;
    assign bus.stallreq_mem    = w_stall;
    assign bus.bus_err         = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_data_sram_slave : transaction-level model bench, WAIT_CYCLES=0 and =3 DUTs
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_data_sram_slave;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_sram_slave_if bus0 ();
    data_sram_slave_if bus3 ();

    data_sram_slave #(.ADDR_W(12), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    data_sram_slave #(.ADDR_W(12), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    int          n_checks = 0;
    int          n_fail   = 0;
    int          stall_hi3 = 0;
    bit          cmp_on   = 1'b0;
    logic [31:0] model_mem [2][4096];
    logic [31:0] exp_rdata [2];
    logic [31:0] pend_rdata[2];
    logic        exp_stall [2];
    logic        exp_err   [2];
    logic        pend_rv   [2];
    logic        pend_err  [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("rdata0", bus0.data_sram_rdata, exp_rdata[0]);
            check("stall0", 32'(bus0.stallreq_mem), 32'(exp_stall[0]));
            check("err0",   32'(bus0.bus_err),      32'(exp_err[0]));
            check("rdata3", bus3.data_sram_rdata, exp_rdata[1]);
            check("stall3", 32'(bus3.stallreq_mem), 32'(exp_stall[1]));
            check("err3",   32'(bus3.bus_err),      32'(exp_err[1]));
            if (bus3.stallreq_mem) stall_hi3++;
        end
    end

    task automatic drive(input int d, input logic en, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (d == 0) begin
            bus0.data_sram_en = en; bus0.data_sram_we = we;
            bus0.data_sram_addr = addr; bus0.data_sram_wdata = wdata;
        end else begin
            bus3.data_sram_en = en; bus3.data_sram_we = we;
            bus3.data_sram_addr = addr; bus3.data_sram_wdata = wdata;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_rdata[d] = '0; exp_stall[d] = 1'b0; exp_err[d] = 1'b0;
            pend_rv[d] = 1'b0; pend_err[d] = 1'b0; pend_rdata[d] = '0;
        end
    endtask

    // Start a new cycle: retire last cycle's completions, park both buses on random masked requests.
    task automatic step();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (pend_rv[d]) exp_rdata[d] = pend_rdata[d];
            exp_err[d]   = pend_err[d];
            pend_rv[d]   = 1'b0;
            pend_err[d]  = 1'b0;
            exp_stall[d] = 1'b0;
            drive(d, 1'b0, 4'($urandom), $urandom, $urandom);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic txn(input int d, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
        int   k;
        int   idx;
        logic oor;
        k   = (d == 1) ? 3 : 0;
        idx = int'(addr[13:2]);
        oor = (addr[31:14] != 18'd0);
        step();
        drive(d, 1'b1, we, addr, wdata);
        if (we == 4'h0 && k > 0) begin
            exp_stall[d] = 1'b1;
            for (int i = 1; i < k; i++) begin
                step();
                drive(d, 1'b1, we, addr, wdata);
                exp_stall[d] = 1'b1;
            end
            step();
            drive(d, 1'b1, we, addr, wdata);
        end
        if (we != 4'h0) begin
            if (!oor)
                for (int b = 0; b < 4; b++)
                    if (we[b]) model_mem[d][idx][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            pend_rv[d]    = 1'b1;
            pend_rdata[d] = oor ? 32'h0 : model_mem[d][idx];
        end
        pend_err[d] = oor;
    endtask

    function automatic logic [31:0] rand_addr();
        int          w;
        logic [31:0] a;
        w = int'($urandom_range(0, 63));
        if ($urandom_range(0, 9) == 0)
            a = $urandom | (32'h0001_0000 << $urandom_range(0, 15));
        else
            a = {18'd0, 12'((w < 32) ? w : 4032 + w), 2'($urandom)};
        return a;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s;
        int          d;
        logic [3:0]  we;
        model_reset();
        for (int i = 0; i < 2; i++) drive(i, 1'b0, 4'h0, 32'h0, 32'h0);
        cmp_on = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_rdata0", bus0.data_sram_rdata, 32'h0);
        check("reset_stall3", 32'(bus3.stallreq_mem), 32'h0);
        check("reset_err3", 32'(bus3.bus_err), 32'h0);

        // Lane writes and back-to-back read-after-write, no wait states.
        txn(0, 4'hF, 32'h10, 32'hDEADBEEF);
        txn(0, 4'h0, 32'h10, 32'h0);
        idle(1);
        check("rd_full", bus0.data_sram_rdata, 32'hDEADBEEF);
        check("model_full", exp_rdata[0], 32'hDEADBEEF);
        txn(0, 4'b0100, 32'h10, 32'h00AA0000);
        txn(0, 4'h0, 32'h10, 32'h0);
        idle(1);
        check("rd_lane", bus0.data_sram_rdata, 32'hDEAABEEF);
        check("model_lane", exp_rdata[0], 32'hDEAABEEF);
        txn(0, 4'hF, 32'h20, 32'h12345678);
        txn(0, 4'h0, 32'h20, 32'h0);
        idle(1);
        check("raw_b2b", bus0.data_sram_rdata, 32'h12345678);

        // Out-of-range read and write.
        txn(0, 4'hF, 32'h0, 32'hCAFEF00D);
        txn(0, 4'h0, 32'h0001_0000, 32'h0);
        idle(1);
        check("oor_rd_data", bus0.data_sram_rdata, 32'h0);
        check("oor_rd_err", 32'(bus0.bus_err), 32'h1);
        idle(1);
        check("oor_err_pulse", 32'(bus0.bus_err), 32'h0);
        txn(0, 4'hF, 32'h0001_0000, 32'h11111111);
        idle(1);
        check("oor_wr_err", 32'(bus0.bus_err), 32'h1);
        txn(0, 4'h0, 32'h0, 32'h0);
        idle(1);
        check("oor_wr_dropped", bus0.data_sram_rdata, 32'hCAFEF00D);

        // Masked requests leave array and rdata alone.
        idle(10);
        check("masked_rdata", bus0.data_sram_rdata, 32'hCAFEF00D);
        txn(0, 4'h0, 32'h10, 32'h0);
        idle(1);
        check("masked_array", bus0.data_sram_rdata, 32'hDEAABEEF);

        // Wait states on the WAIT_CYCLES=3 instance.
        txn(1, 4'hF, 32'h10, 32'hA5A55A5A);
        s = stall_hi3;
        txn(1, 4'h0, 32'h10, 32'h0);
        idle(1);
        check("wait_rdata", bus3.data_sram_rdata, 32'hA5A55A5A);
        check("wait_stall_cycles", 32'(stall_hi3 - s), 32'd3);

        // Reset in the middle of a stalled read.
        step(); drive(1, 1'b1, 4'h0, 32'h10, 32'h0); exp_stall[1] = 1'b1;
        step(); drive(1, 1'b1, 4'h0, 32'h10, 32'h0); exp_stall[1] = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_stall", 32'(bus3.stallreq_mem), 32'h0);
        check("midrst_rdata", bus3.data_sram_rdata, 32'h0);
        idle(2);
        rst_n = 1'b1;
        txn(1, 4'h0, 32'h10, 32'h0);
        idle(1);
        check("post_rst_read", bus3.data_sram_rdata, 32'hA5A55A5A);

        // Fill the random address pool, then random traffic against the model.
        for (int w = 0; w < 64; w++)
            for (int i = 0; i < 2; i++)
                txn(i, 4'hF, {18'd0, 12'((w < 32) ? w : 4032 + w), 2'b00}, $urandom);
        for (int t = 0; t < 400; t++) begin
            d  = int'($urandom_range(0, 1));
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            txn(d, we, rand_addr(), $urandom);
        end
        idle(2);
        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
